// File: rtl/enc16_4_seq.sv
// Sequential 16-to-4 encoder: takes a 16-bit request vector and emits one index per set bit.
// Optional macro ENC16_MSB_FIRST_EN emits the highest index first instead of the lowest.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a request vector, in_ready high
// S_SCAN | emitting indices of bits still in pend, out_valid high
module enc16_4_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  out_cnt,
    output logic        zero_drop
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pend;
    logic [15:0] pend_nxt;
    logic [4:0]  cnt_nxt;
    logic        zd_nxt;
    logic [4:0]  vec_pop;

    always_comb begin
        vec_pop = '0;
        for (int i = 0; i < 16; i++) begin
            vec_pop = vec_pop + {4'd0, in_vec[i]};
        end
    end

    // Priority pick over pend; the last match in loop order wins.
    always_comb begin
        out_idx = '0;
`ifdef ENC16_MSB_FIRST_EN
        for (int i = 0; i < 16; i++) begin
            if (pend[i]) out_idx = 4'(i);
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) out_idx = 4'(i);
        end
`endif
    end

    assign out_last = (pend != 16'd0) && ((pend & (pend - 16'd1)) == 16'd0);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        cnt_nxt   = out_cnt;
        zd_nxt    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_nxt = vec_pop;
                    if (in_vec == 16'd0) begin
                        zd_nxt = 1'b1;
                    end else begin
                        pend_nxt  = in_vec;
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pend_nxt = pend & ~(16'd1 << out_idx);
                    if (out_last) state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pend      <= '0;
            out_cnt   <= '0;
            zero_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            out_cnt   <= cnt_nxt;
            zero_drop <= zd_nxt;
        end
    end

endmodule
